// File: rtl/alu_muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
package alu_muldiv_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } muldiv_state_e;

    function automatic logic is_div_op(muldiv_op_e op);
        return op[2];
    endfunction

    // True when rs1 is interpreted as signed (rs2 is signed only for MULH/DIV/REM).
    function automatic logic is_signed_op(muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/alu_muldiv_sequencer_div.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per step.
module alu_div_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quo_nxt,
    output logic [W-1:0] rem_nxt,
    output logic         done
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  quo, rem, dvs;
    logic [CW-1:0] cnt;
    logic [W:0]    trial, diff;

    // The partial remainder stays below the divisor, so W+1 bits hold the trial.
    always_comb begin
        trial = {rem, quo[W-1]};
        diff  = trial - {1'b0, dvs};
        if (diff[W]) begin
            rem_nxt = trial[W-1:0];
            quo_nxt = {quo[W-2:0], 1'b0};
        end else begin
            rem_nxt = diff[W-1:0];
            quo_nxt = {quo[W-2:0], 1'b1};
        end
        done = step && (cnt == CW'(W-1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo <= '0;
            rem <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (start) begin
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
            cnt <= '0;
        end else if (step) begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// RV32M multiply/divide sequencer; stalls the pipeline until the result is ready.
// Optional MULDIV_EARLY_OUT_EN: divides with |A| < |B| complete without iterating.
module alu_muldiv_sequencer
    import alu_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] operand_A,
    input  logic [DATA_WIDTH-1:0] operand_B,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  done,
    output logic                  busy,
    output logic                  hold_pipeline
);

    localparam int W = DATA_WIDTH;

    muldiv_state_e state;
    muldiv_op_e    op_in, op_q;
    logic [W-1:0]  a_q, b_q;
    logic          qneg_q, rneg_q;

    logic          accept, div_op, sgn, a_neg, b_neg, b_zero, ovf, early, special;
    logic [W-1:0]  a_mag, b_mag, spec_val, quo_nxt, rem_nxt, div_res;
    logic          div_start, div_step, div_done;
    logic          a_sx, b_sx;
    logic [2*W-1:0] prod;

    always_comb begin
        op_in  = muldiv_op_e'(funct3);
        accept = start && !flush && (state == S_IDLE);
        div_op = is_div_op(op_in);
        sgn    = is_signed_op(op_in);
        a_neg  = sgn && operand_A[W-1];
        b_neg  = sgn && operand_B[W-1];
        a_mag  = a_neg ? -operand_A : operand_A;
        b_mag  = b_neg ? -operand_B : operand_B;
        b_zero = (operand_B == '0);
        ovf    = sgn && (operand_A == {1'b1, {(W-1){1'b0}}}) && (&operand_B);
`ifdef MULDIV_EARLY_OUT_EN
        early  = !b_zero && !ovf && (a_mag < b_mag);
`else
        early  = 1'b0;
`endif
        special = b_zero || ovf || early;
        // funct3[1] selects the remainder flavour of a divide op.
        if (b_zero)   spec_val = funct3[1] ? operand_A : '1;
        else if (ovf) spec_val = funct3[1] ? '0 : operand_A;
        else          spec_val = funct3[1] ? operand_A : '0;
    end

    assign div_start = accept && div_op && !special;
    assign div_step  = (state == S_DIV) && !flush;

    alu_div_core #(.W(W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .step     (div_step),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt),
        .done     (div_done)
    );

    // 33-bit sign/zero-extended operands; only the low 64 product bits matter.
    always_comb begin
        a_sx = is_signed_op(op_q) && a_q[W-1];
        b_sx = (op_q == OP_MULH) && b_q[W-1];
        prod = {{W{a_sx}}, a_q} * {{W{b_sx}}, b_q};
        if (op_q == OP_REM || op_q == OP_REMU)
            div_res = rneg_q ? -rem_nxt : rem_nxt;
        else
            div_res = qneg_q ? -quo_nxt : quo_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            result <= '0;
            done   <= 1'b0;
            op_q   <= OP_MUL;
            a_q    <= '0;
            b_q    <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    op_q   <= op_in;
                    a_q    <= operand_A;
                    b_q    <= operand_B;
                    qneg_q <= a_neg ^ b_neg;
                    rneg_q <= a_neg;
                    if (!div_op) begin
                        state <= S_MUL;
                    end else if (special) begin
                        result <= spec_val;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        state <= S_DIV;
                    end
                end
                S_MUL: if (flush) begin
                    state <= S_IDLE;
                end else begin
                    result <= (op_q == OP_MUL) ? prod[W-1:0] : prod[2*W-1:W];
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DIV: if (flush) begin
                    state <= S_IDLE;
                end else if (div_done) begin
                    result <= div_res;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy          = (state != S_IDLE);
    assign hold_pipeline = accept || (state == S_MUL) || (state == S_DIV);

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Randomized bench for alu_muldiv_sequencer against a cycle-count/arithmetic model.
module tb_alu_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [2:0]  funct3;
    logic [31:0] operand_A, operand_B, result;
    logic        done, busy, hold_pipeline;

    always #5 clk = ~clk;

    alu_muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .funct3        (funct3),
        .operand_A     (operand_A),
        .operand_B     (operand_B),
        .flush         (flush),
        .result        (result),
        .done          (done),
        .busy          (busy),
        .hold_pipeline (hold_pipeline)
    );

    int nchk = 0;
    int nerr = 0;
    int since = 0;

    // model state: busy, in done cycle, cycles left until done, visible and pending results
    bit          m_busy, m_done;
    int          m_left;
    logic [31:0] m_res, m_pend;

    bit          pin_on;
    string       pin_nm;
    logic [31:0] pin_exp;
    int          pin_lat;

    function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic [63:0]     p;
        bit              ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit     sgn = (f == 3'd4) || (f == 3'd6);
        longint ma = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        longint mb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (f < 3'd4) return 2;
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef MULDIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return 33;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_left = 0; m_res = '0; m_pend = '0;
    endtask

    // Advance the model by one clock edge using the inputs held in the cycle just ended.
    task automatic model_step();
        if (!rst_n) begin model_reset(); return; end
        if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (!m_busy) begin
            if (start && !flush) begin
                m_pend = model_res(funct3, operand_A, operand_B);
                m_left = model_lat(funct3, operand_A, operand_B) - 1;
                m_busy = 1;
                if (m_left == 0) begin m_done = 1; m_res = m_pend; end
            end
        end else if (flush) begin
            m_busy = 0;
        end else begin
            m_left--;
            if (m_left == 0) begin m_done = 1; m_res = m_pend; end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Single compare process: mid-cycle, against the model and any pinned literal.
    always @(negedge clk) begin
        logic exp_hold;
        since++;
        exp_hold = (m_busy && !m_done) || (!m_busy && start && !flush);
        chk("done", 32'(done), 32'(m_done));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("hold_pipeline", 32'(hold_pipeline), 32'(exp_hold));
        chk("result", result, m_res);
        if (done && pin_on) begin
            chk(pin_nm, result, pin_exp);
            chk({pin_nm, " latency"}, 32'(since), 32'(pin_lat));
        end
        if (!m_busy && start && !flush && rst_n) since = 0;
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input int el);
        pin_nm = nm; pin_exp = er; pin_lat = el; pin_on = 1;
        funct3 = f; operand_A = a; operand_B = b; start = 1;
        cyc();
        start = 0;
        for (int n = 0; n < 40 && !done; n++) cyc();
        cyc();
        pin_on = 0;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 0; start = 0; flush = 0; funct3 = 3'd0;
        operand_A = '0; operand_B = '0; pin_on = 0; pin_nm = ""; pin_exp = '0; pin_lat = 0;
        model_reset();
        repeat (2) cyc();
        rst_n = 1;
        cyc();

        run_op("MUL 7*-3",        3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
        run_op("MULHU -1*-1",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        run_op("MULH -1*-1",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
        run_op("MULHSU -1*2",     3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 2);
        run_op("DIV -20/3",       3'd4, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 33);
        run_op("REM -20/3",       3'd6, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 33);
        run_op("DIVU 100/7",      3'd5, 32'd100,       32'd7,         32'd14,        33);
        run_op("DIVU 5/0",        3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("REM 5/0",         3'd6, 32'd5,         32'd0,         32'd5,         1);
        run_op("DIV overflow",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM overflow",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
`ifdef MULDIV_EARLY_OUT_EN
        run_op("DIVU 3/10 early", 3'd5, 32'd3,         32'd10,        32'd0,         1);
`else
        run_op("DIVU 3/10",       3'd5, 32'd3,         32'd10,        32'd0,         33);
`endif

        // flush at cycle 10 of a divide
        funct3 = 3'd4; operand_A = 32'hFFFF_FFEC; operand_B = 32'd3; start = 1;
        cyc();
        start = 0;
        repeat (9) cyc();
        flush = 1;
        cyc();
        flush = 0;
        repeat (3) cyc();
        run_op("DIV after flush", 3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);

        // reset at cycle 15 of a divide
        funct3 = 3'd5; operand_A = 32'd1000; operand_B = 32'd3; start = 1;
        cyc();
        start = 0;
        repeat (14) cyc();
        rst_n = 0;
        model_reset();
        cyc();
        cyc();
        rst_n = 1;
        cyc();
        run_op("DIVU after reset", 3'd5, 32'd1000, 32'd3, 32'd333, 33);

        // random traffic, including starts while busy and occasional flushes
        for (int i = 0; i < 2500; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            funct3    = 3'($urandom_range(0, 7));
            operand_A = rnd_operand();
            operand_B = rnd_operand();
            flush     = ($urandom_range(0, 29) == 0);
            cyc();
        end
        start = 0; flush = 0;
        repeat (40) cyc();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_sequencer.md
Name: alu_muldiv_sequencer

Overview:
- Sequencer for the RV32M multiply/divide operations of the execute stage.
- Accepts one M-extension op at a time and runs a single-cycle-registered multiply or a 32-step restoring divide.
- Drives hold_pipeline so the pipeline stalls until the result is valid.
- Sits beside the base ALU; its result is muxed into the ALU result path by execute-stage logic.

Parameters:
- DATA_WIDTH, 32, operand/result width; divide iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  M-op valid from decode; sampled only in IDLE
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_A  input  DATA_WIDTH  rs1 value (signed view as per op)
- operand_B  input  DATA_WIDTH  rs2 value
- flush  input  1  abort current op (branch/exception squash)
- result  output  DATA_WIDTH  registered result; holds last completed value
- done  output  1  one-cycle pulse, result valid this cycle
- busy  output  1  high in any state other than IDLE
- hold_pipeline  output  1  stall request to pipeline

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, result=0, done=0, busy=0, hold_pipeline=0, all internal registers 0.
- Reset mid-operation clears immediately; no done is produced.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, on start:
  - MUL ops -> MUL.
  - DIV/REM ops with operand_B==0 or signed overflow -> DONE.
  - Other DIV/REM ops -> DIV.
  - Operands and funct3 are latched.
- MUL: a full 64-bit product is formed from sign-/zero-extended 33-bit operands.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
  - Next state is DONE.
- DIV: restoring divide on magnitudes, one quotient bit per cycle, counter 0..DATA_WIDTH-1; after the last step -> DONE.
- Signed fix-up on entry to DONE:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- DONE: result is written, done=1 for one cycle; next state is IDLE.
- Latency (start cycle = 0):
  - MUL ops: done at cycle 2.
  - DIV ops: done at cycle DATA_WIDTH+1 (33).
  - Special-case divides: done at cycle 1.
- Special cases:
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> operand_A.
  - Overflow (DIV, A=0x80000000, B=-1): quotient 0x80000000, remainder 0.
- hold_pipeline = (start & IDLE & ~flush) | MUL | DIV. It is low in the DONE cycle, so the pipeline advances with result valid.
- start while not IDLE is ignored; decode must not issue a new op while hold_pipeline is high.
- flush in any non-IDLE state -> IDLE next cycle; done is not asserted and result is unchanged.
- flush with start in IDLE: start is ignored.
- Back-to-back: start may be accepted in the cycle after DONE (IDLE).

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined, a DIV/DIVU/REM/REMU whose |A| < |B| (B nonzero, no overflow) goes IDLE -> DONE.
  - Quotient 0, remainder = operand_A.
  - done at cycle 1.
- When undefined, such ops take the full DATA_WIDTH iterations with identical results.

Decomposition:
- Package alu_muldiv_pkg:
  - DATA_WIDTH default constant.
  - funct3 op enum (muldiv_op_e).
  - FSM state enum (muldiv_state_e).
  - Helper functions is_div_op and is_signed_op.
- One sub-module, alu_div_core: iterative restoring divider holding the quotient/remainder registers and step counter. It has start/step/done signals and is controlled by the sequencer FSM.
- Multiply stays inline in the sequencer.

Test Plan:
- MUL A=7, B=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB, done at cycle 2; hold_pipeline high at cycles 0-1, low at 2.
- MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU A=-1, B=2 -> 0xFFFFFFFF.
- DIV A=-20, B=3 -> 0xFFFFFFFA (-6), done at cycle 33. REM with the same operands -> 0xFFFFFFFE (-2). DIVU 100/7 -> 14.
- DIVU A=5, B=0 -> 0xFFFFFFFF at cycle 1. REM A=5, B=0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- DIV started, flush at cycle 10 -> IDLE at cycle 11, no done pulse, result unchanged, hold_pipeline low. Same op restarted later -> correct result.
- rst_n low at cycle 15 of a DIV -> all outputs 0 immediately; after release, start accepted normally.
- With MULDIV_EARLY_OUT_EN: DIVU 3/10 -> quotient 0, done at cycle 1. Without the macro: same result, done at cycle 33.
